sprite_rom_arbiter: RTL
=======================

# sprite_rom_arbiter

Shares one single-port, 1-cycle-latency sprite ROM (34×27 pixels, 8-bit, 10-bit address) between two requesters. Port A is the VGA pixel renderer: a row/column stream with strict priority and fixed latency. Port B is a low-rate client such as the hit-test or palette-preview logic, served with a req/ack/valid handshake. The block sits between the sprite renderers and the ROM instance, drives the ROM address, and routes returned data to the owning requester.

## Interface
- `W`, 34: sprite width in pixels.
- `H`, 27: sprite height in pixels; W*H ≤ 1024.
- `TRANSPARENT`, 8'h00: pixel value returned to A for out-of-range coordinates.
- `i_clk2` input 1: pixel clock; also clocks the ROM.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_a_req` input 1: renderer wants a pixel this cycle.
- `i_a_col` input 6: sprite-relative column.
- `i_a_row` input 5: sprite-relative row.
- `o_a_valid` output 1: A result valid.
- `o_a_data` output 8: A pixel.
- `o_a_hit` output 1: A result came from ROM (in range).
- `i_b_req` input 1: B request; level, held until `o_b_ack`.
- `i_b_addr` input 10: B ROM address; stable while `i_b_req` is high.
- `o_b_ack` output 1: one-cycle pulse when B's address is accepted.
- `o_b_valid` output 1: one-cycle pulse when `o_b_data` is valid.
- `o_b_data` output 8: B read data.
- `o_rom_addr` output 10: registered ROM address.
- `i_rom_data` input 8: ROM output, valid one cycle after `o_rom_addr`.

## Operation
- **A address:** `row*W + col`, computed at 10 bits.
  - In range means `col < W` and `row < H`.
- **Per-cycle arbitration (cycle n, combinational):**
  - `i_a_req` and A in range: A owns the ROM slot.
  - `i_a_req` and A out of range: no ROM slot is consumed for A. The result is still queued as TRANSPARENT with hit=0.
  - The slot goes to B when B's FSM is in B_IDLE, `i_b_req` is high, and A does not own the slot.
- **Owner tag pipeline:** 3 stages of {A_ROM, A_TRANSP, B, NONE}, advanced every cycle, with matching 3-stage alignment of the slot grant.
- **B FSM:**
  - B_IDLE → B_WAIT on grant (`o_b_ack`=1 that cycle).
  - B_WAIT → B_DONE when the B tag reaches stage 2.
  - B_DONE → B_IDLE unconditionally (the `o_b_valid` cycle).
  - At most one B transaction is outstanding. A new B grant is possible only in B_IDLE, so the earliest re-grant is the cycle after `o_b_valid`.
- **Starvation:** B is served only in cycles where A is idle or out of range (blanking). There is no forced preemption of A.
- **Undriven address:** `o_rom_addr` holds its previous value when no one owns the slot.

## Timing
- **Edge n+1:** `o_rom_addr` ← winner address. Stage-1 tag set.
- **Edge n+2:** the ROM updates `i_rom_data`.
- **Edge n+3:** `o_a_data` / `o_b_data` are registered from `i_rom_data` or TRANSPARENT per tag. `o_a_valid` / `o_b_valid` are asserted for exactly one cycle.
- **Latency:** A is fixed at 3 cycles from `i_a_req`, whether in range or not. B is 3 cycles from the `o_b_ack` cycle.
- **Throughput:** A gets 1 result per cycle for back-to-back requests. Results return in request order.
- **`o_b_ack`:** combinational in the grant cycle. The requester may drop `i_b_req` on the following edge.
- **`o_b_data`:** holds its value after `o_b_valid` until the next B result. `o_a_data` follows the same rule for A.
- **Reset values:** `o_a_valid`=0, `o_a_data`=0, `o_a_hit`=0, `o_b_ack`=0, `o_b_valid`=0, `o_b_data`=0, `o_rom_addr`=0. FSM is in B_IDLE and all tags are NONE.
- **Reset mid-operation:** in-flight A and B results are discarded and no valid is emitted for them. B must re-request.
- **Simultaneous requests:** when A (in range) and B request in the same cycle, A wins, `o_b_ack`=0, and B stays pending.

## Test plan
- **Reset state:** assert `i_rst` async mid-cycle → all outputs 0 immediately. After release with no requests, no valids for 10 cycles.
- **A stream:** A streams row=2, col 0..33 back-to-back, ROM preloaded with data = addr[7:0] →
  - `o_rom_addr` = 68..101, one cycle after each request.
  - `o_a_valid` is continuous starting 3 cycles after the first request.
  - `o_a_data` = 68..101 (0x44..0x65), `o_a_hit`=1.
- **Out-of-range A with B pending:** A requests col=34,row=0 and col=5,row=27 while B requests addr 0x3FF →
  - A gets two TRANSPARENT results with hit=0.
  - B is acked in the first of those cycles; `o_b_valid` 3 cycles later with data 0xFF.
  - `o_rom_addr` never shows an A address for those cycles.
- **B blocked by A:** B requests during a 20-cycle A in-range burst → `o_b_ack` stays 0 throughout. B is acked in the first cycle after the burst and `o_b_valid` follows 3 cycles later.
- **B back-to-back:** B holds `i_b_req` with addresses 5 then 6 and no A traffic →
  - Acks occur 4 cycles apart.
  - `o_b_valid` pulses return data 0x05 then 0x06, with no overlap.
- **Reset with reads in flight:** `i_rst` pulsed one cycle after both an A grant and a B ack → neither `o_a_valid` nor `o_b_valid` asserts afterwards. B re-request succeeds with the correct data.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Shares one 1-cycle sprite ROM between a strict-priority pixel renderer (A) and a req/ack client (B).
// Results return 3 cycles after the A request or B ack; B gets no ack while an in-range A owns the slot.
module sprite_rom_arbiter #(
    parameter int          W           = 34,
    parameter int          H           = 27,
    parameter logic [7:0]  TRANSPARENT = 8'h00
) (
    input  logic        i_clk2,
    input  logic        i_rst,
    input  logic        i_a_req,
    input  logic [5:0]  i_a_col,
    input  logic [4:0]  i_a_row,
    output logic        o_a_valid,
    output logic [7:0]  o_a_data,
    output logic        o_a_hit,
    input  logic        i_b_req,
    input  logic [9:0]  i_b_addr,
    output logic        o_b_ack,
    output logic        o_b_valid,
    output logic [7:0]  o_b_data,
    output logic [9:0]  o_rom_addr,
    input  logic [7:0]  i_rom_data
);
    // An out-of-range A result and a B grant can share one cycle, so the tag tracks both owners.
    typedef struct packed {
        logic a;
        logic a_rom;
        logic b;
    } tag_t;

    typedef enum logic [1:0] {B_IDLE, B_WAIT, B_DONE} b_state_t;

    localparam logic [5:0] W_COL  = 6'(W);
    localparam logic [4:0] H_ROW  = 5'(H);
    localparam logic [9:0] W_ADDR = 10'(W);

    logic       a_in_range;
    logic       a_owns;
    logic       b_grant;
    logic [9:0] a_addr;
    tag_t       slot_tag;
    tag_t       tag1;
    tag_t       tag2;
    b_state_t   b_state;
    b_state_t   b_state_nxt;

    assign a_in_range = (i_a_col < W_COL) && (i_a_row < H_ROW);
    assign a_addr     = 10'(i_a_row) * W_ADDR + 10'(i_a_col);
    assign a_owns     = i_a_req && a_in_range;
    assign b_grant    = !i_rst && (b_state == B_IDLE) && i_b_req && !a_owns;
    assign o_b_ack    = b_grant;

    always_comb begin
        slot_tag       = '0;
        slot_tag.a     = i_a_req;
        slot_tag.a_rom = a_owns;
        slot_tag.b     = b_grant;
    end

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            b_state <= B_IDLE;
        end else begin
            b_state <= b_state_nxt;
        end
    end

    always_comb begin
        b_state_nxt = b_state;
        case (b_state)
            B_IDLE:  if (b_grant) b_state_nxt = B_WAIT;
            B_WAIT:  if (tag2.b)  b_state_nxt = B_DONE;
            B_DONE:  b_state_nxt = B_IDLE;
            default: b_state_nxt = B_IDLE;
        endcase
    end

    // Address register doubles as stage 1; the ROM output aligns with stage 2.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            o_rom_addr <= '0;
            tag1       <= '0;
            tag2       <= '0;
            o_a_valid  <= 1'b0;
            o_a_data   <= '0;
            o_a_hit    <= 1'b0;
            o_b_valid  <= 1'b0;
            o_b_data   <= '0;
        end else begin
            if (a_owns) begin
                o_rom_addr <= a_addr;
            end else if (b_grant) begin
                o_rom_addr <= i_b_addr;
            end
            tag1      <= slot_tag;
            tag2      <= tag1;
            o_a_valid <= tag2.a;
            o_b_valid <= tag2.b;
            if (tag2.a) begin
                o_a_data <= tag2.a_rom ? i_rom_data : TRANSPARENT;
                o_a_hit  <= tag2.a_rom;
            end
            if (tag2.b) begin
                o_b_data <= i_rom_data;
            end
        end
    end

endmodule
